// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
// Contents:
//   sw_state_t      - FSM state encoding, also shown on the debug LEDs
//   CLK_DIV_DEFAULT - clk cycles per tick (50 MHz in, 100 Hz tick out)
//   DIV_W           - width of the prescaler counter
//   isRunning()     - true in the states where the digit counters advance
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int CLK_DIV_DEFAULT = 500000;
  localparam int DIV_W           = 20;

  function automatic logic isRunning(input sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one clk-synchronous, debounced button level.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   level_i - button level
//   event_o - high for the one cycle in which the level goes 0 -> 1
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic event_o
);

  logic prev_q;

  // History resets to 1 so a button that is held while reset releases
  // looks like it was already high and produces no event.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_i;
    end
  end

  assign event_o = level_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with tick prescaler.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start_stop  - button level, rising edge toggles run/pause
//   lap         - button level, rising edge toggles the frozen lap display
//   clr         - button level, rising edge clears the counters (IDLE/PAUSE)
//   tick        - one-cycle increment pulse for the first digit counter
//   cnt_enable  - digit counter enable, high in RUN and LAP
//   cnt_clear   - digit counter clear, held during reset, pulsed on clear
//   freeze      - display latch hold, high in LAP
//   state       - current FSM state for debug LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clr,
  output logic       tick,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic       freeze,
  output logic [1:0] state
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic             ssEvt;
  logic             lapEvt;
  logic             clrEvt;

  sw_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             clear_q, clear_d;

  edge_detect u_edgeStartStop (
    .clk     (clk),
    .reset   (reset),
    .level_i (start_stop),
    .event_o (ssEvt)
  );

  edge_detect u_edgeLap (
    .clk     (clk),
    .reset   (reset),
    .level_i (lap),
    .event_o (lapEvt)
  );

  edge_detect u_edgeClr (
    .clk     (clk),
    .reset   (reset),
    .level_i (clr),
    .event_o (clrEvt)
  );

  // Next state: only the highest-priority event of a cycle is considered,
  // so a clr arriving with start_stop swallows the start_stop even in the
  // states where clr itself does nothing.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (clrEvt) begin
      if (state_q == IDLE || state_q == PAUSE) begin
        state_d = IDLE;
        clear_d = 1'b1;
      end
    end else if (ssEvt) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        LAP:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lapEvt) begin
      case (state_q)
        RUN:     state_d = LAP;
        LAP:     state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Prescaler: counts every cycle spent running. If the terminal count is
  // reached on the very edge that leaves the running states, the count is
  // parked at its last value instead of wrapping, so the tick is not lost:
  // it is issued one cycle after the run resumes, and tick stays 0 in PAUSE.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (clear_d) begin
      div_d = '0;
    end else if (isRunning(state_q)) begin
      if (div_q == DIV_MAX) begin
        if (isRunning(state_d)) begin
          div_d  = '0;
          tick_d = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // cnt_clear is held high through reset so the downstream digit counters
  // are cleared together with the controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  assign tick       = tick_q;
  assign cnt_clear  = clear_q;
  assign cnt_enable = isRunning(state_q);
  assign freeze     = (state_q == LAP);
  assign state      = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 500000, SHALL set the number of clk cycles per tick (50 MHz to 100 Hz); legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start_stop  input  1  level from debounced, clk-synchronous button; rising edge toggles run/pause.
REQ-005 lap  input  1  level from debounced, clk-synchronous button; rising edge toggles display freeze.
REQ-006 clr  input  1  level from debounced, clk-synchronous button; rising edge requests counter clear.
REQ-007 tick  output  1  one-cycle pulse, drives the first digit counter's increment input.
REQ-008 cnt_enable  output  1  enable to all digit counters; high while timing.
REQ-009 cnt_clear  output  1  one-cycle pulse, drives the digit counters' reset input.
REQ-010 freeze  output  1  display latch hold; high while lap view is shown.
REQ-011 state  output  2  current FSM state encoding, for debug LEDs.

Function
REQ-012 Each button SHALL be edge-detected: event = current level high AND previous-cycle level low; holding a button SHALL produce exactly one event.
REQ-013 The FSM SHALL have states IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-014 The state SHALL update on the clk edge at which an event is detected; outputs SHALL reflect the new state from the next cycle onward.
REQ-015 Event priority within one cycle SHALL be clr > start_stop > lap; lower-priority events in that cycle SHALL be discarded.
REQ-016 IDLE: start_stop -> RUN; clr -> IDLE with cnt_clear pulse; lap ignored.
REQ-017 RUN: start_stop -> PAUSE; lap -> LAP; clr ignored.
REQ-018 LAP: lap -> RUN; start_stop -> PAUSE; clr ignored.
REQ-019 PAUSE: start_stop -> RUN; clr -> IDLE with cnt_clear pulse; lap ignored.
REQ-020 cnt_enable SHALL be high exactly when state is RUN or LAP.
REQ-021 freeze SHALL be high exactly when state is LAP.
REQ-022 The prescaler SHALL be a 20-bit counter div that increments only in RUN or LAP. When div = CLK_DIV-1 it SHALL wrap to 0 and pulse tick for exactly one cycle.
REQ-023 In PAUSE, div SHALL hold its value, so a resumed run keeps the partial tick period. tick SHALL be 0 in IDLE and PAUSE.
REQ-024 cnt_clear SHALL be a registered one-cycle pulse issued in the cycle after the clr event. div SHALL reset to 0 on the same clock edge as the clr event.
REQ-025 tick and cnt_clear SHALL never be high in the same cycle.
REQ-026 The first tick after leaving IDLE SHALL occur exactly CLK_DIV cycles after cnt_enable rises.

Reset
REQ-027 While reset is high: state=IDLE, div=0, tick=0, cnt_enable=0, freeze=0, state output=0. Edge-detector history registers SHALL be set to 1, so a button held through reset produces no event.
REQ-028 cnt_clear SHALL be 1 during reset, so the downstream counters are cleared together with the controller. It SHALL return to 0 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-run SHALL override any same-cycle event.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum (sw_state_t) and the default CLK_DIV constant.
REQ-031 A sub-module edge_detect (one bit, registered history, reset value 1) SHALL be instantiated once per button.
REQ-032 All outputs SHALL be driven from flops or from decode of the state flops only; no combinational path from button inputs to outputs.

Verification (CLK_DIV=4)
REQ-033 Reset, then start_stop held 10 cycles -> state=RUN one cycle after the edge, cnt_enable=1, tick every 4th cycle, only one state change.
REQ-034 Run 6 cycles, then start_stop -> PAUSE, div holds at 2. Resume -> next tick exactly 2 cycles after cnt_enable rises.
REQ-035 Start_stop and clr rising together in PAUSE -> IDLE, cnt_clear pulses once, div=0, no tick.
REQ-036 In RUN, lap pressed -> freeze=1 and ticks continue. Second lap -> freeze=0, state=RUN.
REQ-037 Reset asserted in LAP while lap held high -> all outputs at reset values, cnt_clear=1. After release -> IDLE, no spurious lap event.
REQ-038 clr pressed in RUN -> no state change, no cnt_clear.
